// File: rtl/vga_scan_ctrl.sv
// Pixel-rate divider, raster counters and vblank-gated update-window arbiter for the VGA path.
// Optional frame counter port frame_cnt is built when VGA_SCAN_FRAME_CNT_EN is defined.
module vga_scan_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_TOTAL = 525,
  parameter int unsigned V_DISP  = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        upd_req,
  input  logic        upd_done,
`ifdef VGA_SCAN_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        upd_gnt,
  output logic        upd_ovr,
  output logic        pix_tick,
  output logic [9:0]  h_count,
  output logic [9:0]  v_count,
  output logic        line_end,
  output logic        frame_start
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    V_VB     = 10'(V_DISP);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic [1:0]    st_q, st_d;
  logic          gnt_q, gnt_d, ovr_q, ovr_d, fs_q, fs_d;
  logic          h_last_s, v_last_s, wrap_s, vblank_s;

  assign pix_tick = en & (div_q == DIV_LAST);
  assign h_last_s = (h_q == H_LAST);
  assign v_last_s = (v_q == V_LAST);
  assign line_end = pix_tick & h_last_s;
  assign wrap_s   = line_end & v_last_s;
  assign vblank_s = (v_q >= V_VB);

  // Divider and raster counter next state
  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (en) begin
      if (div_q == DIV_LAST) div_d = '0;
      else                   div_d = div_q + DW'(1);
    end else begin
      div_d = div_q;
    end
    if (pix_tick) begin
      if (h_last_s) begin
        h_d = 10'd0;
        if (v_last_s) v_d = 10'd0;
        else          v_d = v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end else begin
      h_d = h_q;
      v_d = v_q;
    end
  end

  // Update-window arbiter; upd_done beats a coincident revoke
  always_comb begin
    st_d  = st_q;
    ovr_d = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (upd_req) st_d = ST_WAIT;
        else         st_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (!upd_req)     st_d = ST_IDLE;
        else if (vblank_s) st_d = ST_GRANT;
        else              st_d = ST_WAIT;
      end
      ST_GRANT: begin
        if (upd_done) begin
          st_d = ST_IDLE;
        end else if (wrap_s) begin
          st_d  = ST_WAIT;
          ovr_d = 1'b1;
        end else begin
          st_d = ST_GRANT;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    gnt_d = (st_d == ST_GRANT);
    fs_d  = wrap_s;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_q   <= 10'd0;
      v_q   <= 10'd0;
      st_q  <= ST_IDLE;
      gnt_q <= 1'b0;
      ovr_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      st_q  <= st_d;
      gnt_q <= gnt_d;
      ovr_q <= ovr_d;
      fs_q  <= fs_d;
    end
  end

`ifdef VGA_SCAN_FRAME_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;
  assign fcnt_d = fcnt_q + {15'd0, fs_q};

  // Frame timebase, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fcnt_q <= 16'd0;
    else        fcnt_q <= fcnt_d;
  end
  assign frame_cnt = fcnt_q;
`endif

  assign upd_gnt     = gnt_q;
  assign upd_ovr     = ovr_q;
  assign h_count     = h_q;
  assign v_count     = v_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Randomized scoreboard bench for vga_scan_ctrl on a shrunken raster; the reference model
// tracks position as a linear pixel index and the divider as a count of enabled clocks.
module tb_vga_scan_ctrl;
  localparam int CD = 3, HT = 10, VT = 8, VD = 6, NCYC = 20000;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, upd_req = 1'b0, upd_done = 1'b0;
  logic upd_gnt, upd_ovr, pix_tick, line_end, frame_start;
  logic [9:0] h_count, v_count;
  logic [15:0] fcnt_w;

  vga_scan_ctrl #(.CLK_DIV(CD), .H_TOTAL(HT), .V_TOTAL(VT), .V_DISP(VD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .upd_req(upd_req), .upd_done(upd_done),
`ifdef VGA_SCAN_FRAME_CNT_EN
    .frame_cnt(fcnt_w),
`endif
    .upd_gnt(upd_gnt), .upd_ovr(upd_ovr), .pix_tick(pix_tick),
    .h_count(h_count), .v_count(v_count), .line_end(line_end), .frame_start(frame_start)
  );
`ifndef VGA_SCAN_FRAME_CNT_EN
  assign fcnt_w = 16'd0;
`endif

  typedef struct packed {
    logic tick; logic [9:0] h; logic [9:0] v; logic le; logic fs;
    logic gnt; logic ovr; logic [15:0] fc;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0, errors = 0;
  int cov_ovr = 0, cov_fs = 0, cov_rise = 0, n_coinc = 0;

  // Reference model: enabled-clock count, linear pixel index, window phase 0/1/2
  int m_clk, m_pix, m_phase, m_fc;
  bit m_fs, m_ovr;

  always #5 clk = ~clk;

  function automatic bit m_tick();
    return en && rst_n && (m_clk % CD == CD - 1);
  endfunction

  function automatic obs_t m_expect();
    obs_t o;
    o.tick = m_tick();
    o.h    = 10'(m_pix % HT);
    o.v    = 10'(m_pix / HT);
    o.le   = o.tick && (m_pix % HT == HT - 1);
    o.fs   = m_fs;
    o.gnt  = (m_phase == 2);
    o.ovr  = m_ovr;
    o.fc   = 16'(m_fc);
    return o;
  endfunction

  task automatic m_reset();
    m_clk = 0; m_pix = 0; m_phase = 0; m_fc = 0; m_fs = 0; m_ovr = 0;
  endtask

  task automatic m_step();
    bit t, wrap, vb, ovr;
    t    = m_tick();
    wrap = t && (m_pix == HT * VT - 1);
    vb   = (m_pix / HT) >= VD;
    ovr  = 0;
    case (m_phase)
      0: if (upd_req) m_phase = 1;
      1: if (!upd_req) m_phase = 0; else if (vb) m_phase = 2;
      2: if (upd_done) begin m_phase = 0; if (wrap) n_coinc++; end
         else if (wrap) begin m_phase = 1; ovr = 1; end
      default: m_phase = 0;
    endcase
`ifdef VGA_SCAN_FRAME_CNT_EN
    if (m_fs) m_fc = (m_fc + 1) % 65536;
`endif
    m_fs  = wrap;
    m_ovr = ovr;
    if (en) m_clk++;
    if (t) m_pix = (m_pix + 1) % (HT * VT);
  endtask

  // Monitor: compare the DUT against the queued expectation once per cycle
  initial begin
    obs_t e, a;
    logic prev_gnt = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{pix_tick, h_count, v_count, line_end, frame_start, upd_gnt, upd_ovr, fcnt_w};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_obs t=%0t got tick=%b h=%0d v=%0d le=%b fs=%b gnt=%b ovr=%b fc=%0d want tick=%b h=%0d v=%0d le=%b fs=%b gnt=%b ovr=%b fc=%0d",
                   $time, a.tick, a.h, a.v, a.le, a.fs, a.gnt, a.ovr, a.fc,
                   e.tick, e.h, e.v, e.le, e.fs, e.gnt, e.ovr, e.fc);
        end
        if (upd_ovr === 1'b1) cov_ovr++;
        if (frame_start === 1'b1) cov_fs++;
        if (upd_gnt === 1'b1 && prev_gnt === 1'b0) cov_rise++;
        prev_gnt = upd_gnt;
      end
    end
  end

  // Driver: advance model on each edge, then apply new inputs and queue the expectation
  initial begin
    int rst_hold = 0;
    bit did_rst = 0;
    m_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      if (rst_n) m_step();
      #1;
      if (!did_rst && cyc > 9000 && m_phase == 2 && rst_n) begin
        rst_hold = 3;
        did_rst  = 1;
      end
      if (cyc < 3 || rst_hold > 0) begin
        rst_n = 1'b0;
        if (rst_hold > 0) rst_hold--;
      end else begin
        rst_n = 1'b1;
      end
      if (!rst_n) m_reset();

      if (cyc >= 1000 && cyc < 1050) en = 1'b0;
      else en = ($urandom_range(7) != 0);

      if (cyc >= 3000 && cyc < 6000) begin
        upd_req  = 1'b1;
        upd_done = 1'b0;
      end else if (cyc >= 6000 && cyc < 8000) begin
        upd_req  = 1'b1;
        upd_done = (m_phase == 2) && m_tick() && (m_pix == HT * VT - 1);
      end else begin
        if ($urandom_range(39) == 0) upd_req = ~upd_req;
        upd_done = (m_phase == 2) && ($urandom_range(29) == 0);
      end
      exp_q.push_back(m_expect());
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drain got %0d want 0", exp_q.size()); end
    checks++;
    if (cov_ovr == 0) begin errors++; $display("FAIL ovr_seen got %0d want >0", cov_ovr); end
    checks++;
    if (cov_fs == 0) begin errors++; $display("FAIL frame_start_seen got %0d want >0", cov_fs); end
    checks++;
    if (cov_rise == 0) begin errors++; $display("FAIL grant_seen got %0d want >0", cov_rise); end
    checks++;
    if (n_coinc == 0) begin errors++; $display("FAIL coincident_done got %0d want >0", n_coinc); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
